// File: rtl/sfft_frame_scheduler.sv
// rtl/sfft_frame_scheduler.sv - SFFT frame sequencer: input ring writes, hop-based frame launch,
// output bank double-buffering and frame/drop counters.
module sfft_frame_scheduler #(
   parameter int NFFT               = 512,
   parameter int HOP                = 128,
   parameter int SAMPLE_WIDTH       = 24,
   parameter int TIME_COUNTER_WIDTH = 32,
   localparam int AW                = (NFFT > 1) ? $clog2(NFFT) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          advance,
   input  logic [SAMPLE_WIDTH-1:0]       sample_in,
   input  logic                          fft_busy,
   input  logic                          fft_done,
   input  logic                          read_lock,
   output logic                          buf_wr_en,
   output logic [AW-1:0]                 buf_wr_addr,
   output logic [SAMPLE_WIDTH-1:0]       buf_wr_data,
   output logic                          fft_start,
   output logic [AW-1:0]                 fft_base_addr,
   output logic                          write_bank,
   output logic                          read_bank,
   output logic                          output_valid,
   output logic [TIME_COUNTER_WIDTH-1:0] frame_count,
   output logic [15:0]                   dropped_frames
);

   localparam int HW = $clog2(NFFT + 1) + 1;
   localparam int FW = $clog2(NFFT + 1);

   typedef enum logic [2:0] {
      S_FILL,
      S_WAIT_HOP,
      S_START,
      S_RUN,
      S_COMMIT
   } state_t;

   state_t                        state_q, state_d;
   logic                          adv_q, adv_d;
   logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [HW-1:0]                 hop_cnt_q, hop_cnt_d;
   logic [FW-1:0]                 fill_cnt_q, fill_cnt_d;
   logic                          buf_wr_en_q, buf_wr_en_d;
   logic [AW-1:0]                 buf_wr_addr_q, buf_wr_addr_d;
   logic [SAMPLE_WIDTH-1:0]       buf_wr_data_q, buf_wr_data_d;
   logic                          fft_start_q, fft_start_d;
   logic [AW-1:0]                 fft_base_addr_q, fft_base_addr_d;
   logic                          write_bank_q, write_bank_d;
   logic                          read_bank_q, read_bank_d;
   logic                          output_valid_q, output_valid_d;
   logic [TIME_COUNTER_WIDTH-1:0] frame_count_q, frame_count_d;
   logic [15:0]                   dropped_q, dropped_d;
   logic                          adv_rise;
   logic                          hop_full;

   assign adv_rise = advance & ~adv_q;
   assign hop_full = (hop_cnt_q == HW'(HOP));

   always_comb begin
      state_d         = state_q;
      adv_d           = advance;
      wr_ptr_d        = wr_ptr_q;
      hop_cnt_d       = hop_cnt_q;
      fill_cnt_d      = fill_cnt_q;
      buf_wr_en_d     = 1'b0;
      buf_wr_addr_d   = buf_wr_addr_q;
      buf_wr_data_d   = buf_wr_data_q;
      fft_start_d     = 1'b0;
      fft_base_addr_d = fft_base_addr_q;
      write_bank_d    = write_bank_q;
      read_bank_d     = read_bank_q;
      output_valid_d  = output_valid_q;
      frame_count_d   = frame_count_q;
      dropped_d       = dropped_q;

      if (adv_rise) begin
         buf_wr_en_d   = 1'b1;
         buf_wr_addr_d = wr_ptr_q;
         buf_wr_data_d = sample_in;
         wr_ptr_d      = wr_ptr_q + AW'(1);
         hop_cnt_d     = hop_cnt_q + HW'(1);
      end

      // A hop completing while the previous frame is still in flight is skipped.
      if ((state_q == S_RUN || state_q == S_COMMIT) && adv_rise &&
          (hop_cnt_q + HW'(1)) == HW'(HOP)) begin
         hop_cnt_d = '0;
         if (dropped_q != 16'hFFFF) begin
            dropped_d = dropped_q + 16'd1;
         end
      end

      case (state_q)
         S_FILL: begin
            hop_cnt_d = '0;
            if (adv_rise) begin
               if (fill_cnt_q == FW'(NFFT - 1)) begin
                  fill_cnt_d = '0;
                  state_d    = S_START;
               end else begin
                  fill_cnt_d = fill_cnt_q + FW'(1);
               end
            end
         end
         S_WAIT_HOP: begin
            if (hop_full) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (!fft_busy) begin
               fft_start_d     = 1'b1;
               fft_base_addr_d = wr_ptr_q;
               hop_cnt_d       = adv_rise ? HW'(1) : '0;
               state_d         = S_RUN;
            end
         end
         S_RUN: begin
            if (fft_done) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (!read_lock) begin
               write_bank_d   = ~write_bank_q;
               read_bank_d    = ~read_bank_q;
               output_valid_d = 1'b1;
               frame_count_d  = frame_count_q + TIME_COUNTER_WIDTH'(1);
               state_d        = hop_full ? S_START : S_WAIT_HOP;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_FILL;
         adv_q           <= 1'b1;
         wr_ptr_q        <= '0;
         hop_cnt_q       <= '0;
         fill_cnt_q      <= '0;
         buf_wr_en_q     <= 1'b0;
         buf_wr_addr_q   <= '0;
         buf_wr_data_q   <= '0;
         fft_start_q     <= 1'b0;
         fft_base_addr_q <= '0;
         write_bank_q    <= 1'b0;
         read_bank_q     <= 1'b1;
         output_valid_q  <= 1'b0;
         frame_count_q   <= '0;
         dropped_q       <= '0;
      end else begin
         state_q         <= state_d;
         adv_q           <= adv_d;
         wr_ptr_q        <= wr_ptr_d;
         hop_cnt_q       <= hop_cnt_d;
         fill_cnt_q      <= fill_cnt_d;
         buf_wr_en_q     <= buf_wr_en_d;
         buf_wr_addr_q   <= buf_wr_addr_d;
         buf_wr_data_q   <= buf_wr_data_d;
         fft_start_q     <= fft_start_d;
         fft_base_addr_q <= fft_base_addr_d;
         write_bank_q    <= write_bank_d;
         read_bank_q     <= read_bank_d;
         output_valid_q  <= output_valid_d;
         frame_count_q   <= frame_count_d;
         dropped_q       <= dropped_d;
      end
   end

   assign buf_wr_en      = buf_wr_en_q;
   assign buf_wr_addr    = buf_wr_addr_q;
   assign buf_wr_data    = buf_wr_data_q;
   assign fft_start      = fft_start_q;
   assign fft_base_addr  = fft_base_addr_q;
   assign write_bank     = write_bank_q;
   assign read_bank      = read_bank_q;
   assign output_valid   = output_valid_q;
   assign frame_count    = frame_count_q;
   assign dropped_frames = dropped_q;

endmodule

// File: tb/tb_sfft_frame_scheduler.sv
// tb/tb_sfft_frame_scheduler.sv - directed bench for sfft_frame_scheduler (NFFT=16, HOP=4).
module tb_sfft_frame_scheduler;

   localparam int NFFT = 16;
   localparam int HOP  = 4;
   localparam int SW   = 24;
   localparam int TCW  = 32;

   logic           clk;
   logic           reset;
   logic           advance;
   logic [SW-1:0]  sample_in;
   logic           fft_busy;
   logic           fft_done;
   logic           read_lock;
   logic           buf_wr_en;
   logic [3:0]     buf_wr_addr;
   logic [SW-1:0]  buf_wr_data;
   logic           fft_start;
   logic [3:0]     fft_base_addr;
   logic           write_bank;
   logic           read_bank;
   logic           output_valid;
   logic [TCW-1:0] frame_count;
   logic [15:0]    dropped_frames;

   sfft_frame_scheduler #(
      .NFFT(NFFT), .HOP(HOP), .SAMPLE_WIDTH(SW), .TIME_COUNTER_WIDTH(TCW)
   ) dut (
      .clk(clk), .reset(reset), .advance(advance), .sample_in(sample_in),
      .fft_busy(fft_busy), .fft_done(fft_done), .read_lock(read_lock),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .fft_start(fft_start), .fft_base_addr(fft_base_addr),
      .write_bank(write_bank), .read_bank(read_bank), .output_valid(output_valid),
      .frame_count(frame_count), .dropped_frames(dropped_frames)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int wr_cnt   = 0;
   int start_cnt = 0;
   int addr_err = 0;
   int exp_addr = 0;
   logic [3:0]    last_addr = '0;
   logic [SW-1:0] last_data = '0;
   logic [3:0]    last_base = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (buf_wr_en === 1'b1) begin
         if (buf_wr_addr !== exp_addr[3:0]) addr_err++;
         exp_addr  = (exp_addr + 1) % NFFT;
         last_addr = buf_wr_addr;
         last_data = buf_wr_data;
         wr_cnt++;
      end
      if (fft_start === 1'b1) begin
         start_cnt++;
         last_base = fft_base_addr;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_sample(input logic [SW-1:0] d);
      advance   = 1'b1;
      sample_in = d;
      tick(3);
      advance = 1'b0;
      tick(1);
   endtask

   task automatic pulse_done();
      fft_done = 1'b1;
      tick(1);
      fft_done = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_wr_en"}, 32'(buf_wr_en), 32'd0);
      check({tag, "_wr_addr"}, 32'(buf_wr_addr), 32'd0);
      check({tag, "_wr_data"}, 32'(buf_wr_data), 32'd0);
      check({tag, "_start"}, 32'(fft_start), 32'd0);
      check({tag, "_base"}, 32'(fft_base_addr), 32'd0);
      check({tag, "_wbank"}, 32'(write_bank), 32'd0);
      check({tag, "_rbank"}, 32'(read_bank), 32'd1);
      check({tag, "_valid"}, 32'(output_valid), 32'd0);
      check({tag, "_fcount"}, frame_count, 32'd0);
      check({tag, "_dropped"}, 32'(dropped_frames), 32'd0);
   endtask

   int frozen_err;
   int s_start;
   int s_wr;

   initial begin
      reset     = 1'b1;
      advance   = 1'b0;
      sample_in = '0;
      fft_busy  = 1'b0;
      fft_done  = 1'b0;
      read_lock = 1'b0;
      tick(3);
      check_reset_state("rst");
      reset = 1'b0;
      tick(2);

      // Initial fill: 15 samples give writes 0..14 and no launch.
      for (int i = 0; i < 15; i++) send_sample(SW'(24'h100 + i));
      check("fill15_wr_cnt", 32'(wr_cnt), 32'd15);
      check("fill15_addr_seq", 32'(addr_err), 32'd0);
      check("fill15_last_addr", 32'(last_addr), 32'd14);
      check("fill15_last_data", 32'(last_data), 32'h10E);
      check("fill15_no_start", 32'(start_cnt), 32'd0);
      send_sample(24'h10F);
      check("fill16_start", 32'(start_cnt), 32'd1);
      check("fill16_base", 32'(last_base), 32'd0);
      check("fill16_wr_cnt", 32'(wr_cnt), 32'd16);

      // First commit, then one hop of 4 samples relaunches at ring address 4.
      pulse_done();
      check("commit1_pre_fcount", frame_count, 32'd0);
      tick(1);
      check("commit1_wbank", 32'(write_bank), 32'd1);
      check("commit1_rbank", 32'(read_bank), 32'd0);
      check("commit1_valid", 32'(output_valid), 32'd1);
      check("commit1_fcount", frame_count, 32'd1);
      for (int i = 0; i < 4; i++) send_sample(SW'(24'h200 + i));
      check("hop_start", 32'(start_cnt), 32'd2);
      check("hop_base", 32'(last_base), 32'd4);

      // 9 samples while RUN: hops complete at samples 4 and 8, leaving hop_cnt=1.
      for (int i = 0; i < 9; i++) send_sample(SW'(24'h300 + i));
      check("drop_count", 32'(dropped_frames), 32'd2);
      check("drop_no_start", 32'(start_cnt), 32'd2);
      pulse_done();
      tick(1);
      check("commit2_fcount", frame_count, 32'd2);
      check("commit2_wbank", 32'(write_bank), 32'd0);
      check("commit2_rbank", 32'(read_bank), 32'd1);
      for (int i = 0; i < 2; i++) send_sample(SW'(24'h400 + i));
      check("drop_hop_early", 32'(start_cnt), 32'd2);
      send_sample(24'h402);
      check("drop_hop_start", 32'(start_cnt), 32'd3);
      check("drop_hop_base", 32'(last_base), 32'd0);
      check("drop_hop_data", 32'(last_data), 32'h402);

      // Commit held off by read_lock.
      read_lock = 1'b1;
      pulse_done();
      frozen_err = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (write_bank !== 1'b0 || read_bank !== 1'b1 || frame_count !== 32'd2) frozen_err++;
      end
      check("lock_frozen", 32'(frozen_err), 32'd0);
      read_lock = 1'b0;
      check("lock_pre_fcount", frame_count, 32'd2);
      tick(1);
      check("lock_release_fcount", frame_count, 32'd3);
      check("lock_release_wbank", 32'(write_bank), 32'd1);
      check("lock_release_rbank", 32'(read_bank), 32'd0);

      // Busy pipeline delays the launch past the hop point by 2 samples.
      fft_busy = 1'b1;
      for (int i = 0; i < 6; i++) send_sample(SW'(24'h500 + i));
      check("busy_no_start", 32'(start_cnt), 32'd3);
      fft_busy = 1'b0;
      tick(3);
      check("busy_start", 32'(start_cnt), 32'd4);
      check("busy_base", 32'(last_base), 32'd6);
      check("busy_no_drop", 32'(dropped_frames), 32'd2);

      // Reset while in RUN; a late fft_done must be ignored.
      reset = 1'b1;
      tick(1);
      check_reset_state("midrst");
      reset = 1'b0;
      exp_addr = 0;
      tick(1);
      pulse_done();
      tick(2);
      check("midrst_done_wbank", 32'(write_bank), 32'd0);
      check("midrst_done_fcount", frame_count, 32'd0);
      check("midrst_done_valid", 32'(output_valid), 32'd0);
      s_start = start_cnt;
      s_wr    = wr_cnt;
      for (int i = 0; i < 15; i++) send_sample(SW'(24'h600 + i));
      check("refill15_no_start", 32'(start_cnt - s_start), 32'd0);
      check("refill15_wr_cnt", 32'(wr_cnt - s_wr), 32'd15);
      check("refill15_last_addr", 32'(last_addr), 32'd14);
      check("all_addr_seq", 32'(addr_err), 32'd0);
      send_sample(24'h60F);
      check("refill16_start", 32'(start_cnt - s_start), 32'd1);
      check("refill16_base", 32'(last_base), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
